// File: rtl/data_port_pkg.sv
// -----------------------------------------------------------------------------
// data_port_pkg
// Shared definitions for the data-side port B arbiter: default widths, the
// line-offset size, the sequencer state encoding and requester identifiers.
// Optional build macro used by the block: DATA_PORT_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package data_port_pkg;

  localparam int ADDR_WIDTH_DEF   = 17;
  localparam int RAM_WIDTH_DEF    = 128;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef logic owner_t;
  localparam owner_t OWNER_REQ0 = 1'b0;
  localparam owner_t OWNER_REQ1 = 1'b1;

  // Pointer value after reset: "req1 granted last" so req0 wins the first tie.
  localparam owner_t RR_RESET_LAST = OWNER_REQ1;

endpackage

// File: rtl/data_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_port_arbiter_if
// Bundles the global ready, both requester handshakes and the port B pins.
//   master : requesters + memory side (drives valids, addresses, dout_b, rdy)
//   slave  : the arbiter (drives readies, responses, addr_b/din_b/we_b)
// -----------------------------------------------------------------------------
interface data_port_arbiter_if
  import data_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF
);
  logic                  rdy;

  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  req0_resp_valid;
  logic [RAM_WIDTH-1:0]  req0_resp_data;

  logic                  req1_valid;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [RAM_WIDTH-1:0]  req1_wdata;
  logic                  req1_ready;
  logic                  req1_resp_valid;
  logic [RAM_WIDTH-1:0]  req1_resp_data;

  logic [ADDR_WIDTH-1:0] addr_b;
  logic [RAM_WIDTH-1:0]  din_b;
  logic                  we_b;
  logic [RAM_WIDTH-1:0]  dout_b;

  modport master (
    output rdy,
    output req0_valid, req0_addr,
    input  req0_ready, req0_resp_valid, req0_resp_data,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_resp_valid, req1_resp_data,
    input  addr_b, din_b, we_b,
    output dout_b
  );

  modport slave (
    input  rdy,
    input  req0_valid, req0_addr,
    output req0_ready, req0_resp_valid, req0_resp_data,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_resp_valid, req1_resp_data,
    output addr_b, din_b, we_b,
    input  dout_b
  );
endinterface

// File: rtl/data_port_picker.sv
// -----------------------------------------------------------------------------
// data_port_picker
// Combinational grant selection between the two requesters.
// Build macro DATA_PORT_ROUND_ROBIN_EN:
//   defined   - round robin; on a tie the requester not granted last wins.
//               Adds clk/rst/take_i ports and the last-grant pointer register.
//   undefined - fixed priority, req0 wins every tie.
// Ports:
//   valid0_i/valid1_i : request valids
//   take_i            : a grant is being consumed this cycle (RR build only)
//   any_o             : at least one request present
//   owner_o           : selected requester (0 = req0, 1 = req1)
// -----------------------------------------------------------------------------
module data_port_picker
  import data_port_pkg::*;
(
`ifdef DATA_PORT_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   take_i,
`endif
  input  logic   valid0_i,
  input  logic   valid1_i,
  output logic   any_o,
  output owner_t owner_o
);

  assign any_o = valid0_i | valid1_i;

`ifdef DATA_PORT_ROUND_ROBIN_EN
  owner_t last_q;
  owner_t last_d;

  // Winner selection; a tie goes to whoever was not granted last.
  always_comb begin
    owner_o = OWNER_REQ0;
    if (valid0_i && valid1_i) begin
      owner_o = (last_q == OWNER_REQ0) ? OWNER_REQ1 : OWNER_REQ0;
    end else if (valid1_i) begin
      owner_o = OWNER_REQ1;
    end else begin
      owner_o = OWNER_REQ0;
    end
  end

  // Pointer follows every consumed grant.
  always_comb begin
    last_d = last_q;
    if (take_i) begin
      last_d = owner_o;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= RR_RESET_LAST;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: req1 only when req0 is absent.
  always_comb begin
    owner_o = OWNER_REQ0;
    if (!valid0_i && valid1_i) begin
      owner_o = OWNER_REQ1;
    end else begin
      owner_o = OWNER_REQ0;
    end
  end
`endif

endmodule

// File: rtl/data_port_arbiter.sv
// -----------------------------------------------------------------------------
// data_port_arbiter
// Shares memory port B (1-cycle read latency, 1-cycle write) between req0
// (read-only cache refill) and req1 (read/write writeback path). A four-state
// sequencer IDLE -> ISSUE -> [WAIT] -> RESP serves one line request at a time.
// Build macro DATA_PORT_ROUND_ROBIN_EN selects round-robin tie breaking
// (default: fixed priority to req0).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : data_port_arbiter_if.slave - rdy, both requester handshakes,
//              addr_b/din_b/we_b/dout_b port B pins
// rdy low freezes every register; we_b, ready and resp_valid are gated off
// so a pending pulse simply reappears once rdy returns.
// -----------------------------------------------------------------------------
module data_port_arbiter
  import data_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF
) (
  input logic                clk,
  input logic                rst,
  data_port_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH - LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

  state_e                state_q,  state_d;
  owner_t                owner_q,  owner_d;
  logic                  write_q,  write_d;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [RAM_WIDTH-1:0]  wdata_q,  wdata_d;
  logic [RAM_WIDTH-1:0]  resp0_q,  resp0_d;
  logic [RAM_WIDTH-1:0]  resp1_q,  resp1_d;

  logic   pick_any_s;
  owner_t pick_owner_s;

`ifdef DATA_PORT_ROUND_ROBIN_EN
  logic take_s;
  assign take_s = bus.rdy & (state_q == IDLE) & pick_any_s;
`endif

  data_port_picker u_picker (
`ifdef DATA_PORT_ROUND_ROBIN_EN
    .clk      (clk),
    .rst      (rst),
    .take_i   (take_s),
`endif
    .valid0_i (bus.req0_valid),
    .valid1_i (bus.req1_valid),
    .any_o    (pick_any_s),
    .owner_o  (pick_owner_s)
  );

  // Sequencer next state and datapath capture; nothing moves while rdy is low.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp0_d = resp0_q;
    resp1_d = resp1_q;
    if (bus.rdy) begin
      case (state_q)
        IDLE: begin
          if (pick_any_s) begin
            state_d = ISSUE;
            owner_d = pick_owner_s;
            if (pick_owner_s == OWNER_REQ1) begin
              // req0 is read-only, so only req1 can carry a write.
              write_d = bus.req1_write;
              addr_d  = bus.req1_addr & LINE_MASK;
              wdata_d = bus.req1_wdata;
            end else begin
              write_d = 1'b0;
              addr_d  = bus.req0_addr & LINE_MASK;
              wdata_d = {RAM_WIDTH{1'b0}};
            end
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          if (write_q) begin
            // Writes answer with an all-zero line.
            state_d = RESP;
            if (owner_q == OWNER_REQ1) begin
              resp1_d = {RAM_WIDTH{1'b0}};
            end else begin
              resp0_d = {RAM_WIDTH{1'b0}};
            end
          end else begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          // addr_b has been stable for a cycle, so dout_b holds the line.
          state_d = RESP;
          if (owner_q == OWNER_REQ1) begin
            resp1_d = bus.dout_b;
          end else begin
            resp0_d = bus.dout_b;
          end
        end
        RESP: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWNER_REQ0;
      write_q <= 1'b0;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {RAM_WIDTH{1'b0}};
      resp0_q <= {RAM_WIDTH{1'b0}};
      resp1_q <= {RAM_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp0_q <= resp0_d;
      resp1_q <= resp1_d;
    end
  end

  // Pulses are decoded from registered state and gated only by rdy.
  assign bus.addr_b          = addr_q;
  assign bus.din_b           = wdata_q;
  assign bus.we_b            = bus.rdy & (state_q == ISSUE) & write_q;
  assign bus.req0_ready      = bus.rdy & (state_q == ISSUE) & (owner_q == OWNER_REQ0);
  assign bus.req1_ready      = bus.rdy & (state_q == ISSUE) & (owner_q == OWNER_REQ1);
  assign bus.req0_resp_valid = bus.rdy & (state_q == RESP)  & (owner_q == OWNER_REQ0);
  assign bus.req1_resp_valid = bus.rdy & (state_q == RESP)  & (owner_q == OWNER_REQ1);
  assign bus.req0_resp_data  = resp0_q;
  assign bus.req1_resp_data  = resp1_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_port_arbiter
// Self-checking bench for data_port_arbiter. A transaction-level model
// (grant policy, per-request latency counted in rdy-high cycles, line memory
// as an associative array) predicts every output each cycle; directed
// sequences add literal expectations. Honours DATA_PORT_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_data_port_arbiter;
  import data_port_pkg::*;

  localparam int AW = 17;
  localparam int RW = 128;
`ifdef DATA_PORT_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_port_arbiter_if #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) bus ();

  data_port_arbiter #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Port B memory: 1-cycle read latency, write on we_b.
  logic [RW-1:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus.we_b) ram[bus.addr_b[AW-1:4]] <= bus.din_b;
    bus.dout_b <= ram[bus.addr_b[AW-1:4]];
  end

  function automatic logic [RW-1:0] init_line(input int i);
    return {32'(i) ^ 32'hDEAD0000, 32'(i * 3), ~32'(i), 32'(i) + 32'h0000_1234};
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic          m_busy;
  int            m_age;       // rdy-high cycles since capture (1 = issue cycle)
  logic          m_owner;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_last_addr;
  logic [RW-1:0] m_wdata;
  logic          m_rr_last;
  logic [RW-1:0] mem_model [int];

  function automatic logic [RW-1:0] mem_rd(input int idx);
    if (mem_model.exists(idx)) return mem_model[idx];
    return init_line(idx);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 1'b0; m_write = 1'b0;
    m_addr = '0; m_last_addr = '0; m_wdata = '0; m_rr_last = 1'b1;
  endtask

  task automatic model_step();
    logic win;
    int   last;
    if (bus.rdy && m_busy && m_age == 1 && m_write) mem_model[int'(m_addr >> 4)] = m_wdata;
    if (rst) begin
      model_reset();
    end else if (bus.rdy) begin
      if (m_busy) begin
        last = m_write ? 2 : 3;
        if (m_age == last) m_busy = 1'b0;
        else m_age++;
      end else if (bus.req0_valid || bus.req1_valid) begin
        if (bus.req0_valid && bus.req1_valid) win = RR_MODE ? !m_rr_last : 1'b0;
        else win = bus.req1_valid;
        m_rr_last   = win;
        m_owner     = win;
        m_write     = win && bus.req1_write;
        m_addr      = win ? bus.req1_addr : bus.req0_addr;
        m_addr[3:0] = 4'h0;
        m_last_addr = m_addr;
        m_wdata     = win ? bus.req1_wdata : '0;
        m_busy      = 1'b1;
        m_age       = 1;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic          saw_r0, saw_r1, saw_v0, saw_v1, saw_we;
  logic [AW-1:0] saw_addr;
  logic [RW-1:0] saw_d0, saw_d1;
  int            we_cnt  = 0;
  int            rv0_cnt = 0;

  task automatic compare();
    logic e_r0, e_r1, e_v0, e_v1, e_we, issue, resp;
    issue = bus.rdy && m_busy && m_age == 1;
    resp  = bus.rdy && m_busy && m_age == (m_write ? 2 : 3);
    e_r0 = issue && !m_owner;
    e_r1 = issue &&  m_owner;
    e_we = issue &&  m_write;
    e_v0 = resp  && !m_owner;
    e_v1 = resp  &&  m_owner;
    chk("req0_ready", RW'(bus.req0_ready), RW'(e_r0));
    chk("req1_ready", RW'(bus.req1_ready), RW'(e_r1));
    chk("req0_resp_valid", RW'(bus.req0_resp_valid), RW'(e_v0));
    chk("req1_resp_valid", RW'(bus.req1_resp_valid), RW'(e_v1));
    chk("we_b", RW'(bus.we_b), RW'(e_we));
    chk("addr_b", RW'(bus.addr_b), RW'(m_last_addr));
    if (e_we) chk("din_b", bus.din_b, m_wdata);
    if (e_v0) chk("req0_resp_data", bus.req0_resp_data, mem_rd(int'(m_addr >> 4)));
    if (e_v1) chk("req1_resp_data", bus.req1_resp_data,
                  m_write ? {RW{1'b0}} : mem_rd(int'(m_addr >> 4)));
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    saw_r0 = bus.req0_ready;      saw_r1 = bus.req1_ready;
    saw_v0 = bus.req0_resp_valid; saw_v1 = bus.req1_resp_valid;
    saw_we = bus.we_b;            saw_addr = bus.addr_b;
    saw_d0 = bus.req0_resp_data;  saw_d1 = bus.req1_resp_data;
    if (saw_we) we_cnt++;
    if (saw_v0) rv0_cnt++;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one request and run it to its response; latencies relative to valid.
  task automatic do_req(input logic who, input logic wr, input logic [AW-1:0] a,
                        input logic [RW-1:0] d, output int t_ready, output int t_resp,
                        output logic [RW-1:0] rdata);
    int t0;
    bit done;
    t_ready = -1; t_resp = -1; rdata = '0; done = 1'b0;
    if (!who) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end
    t0 = cyc;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (who ? saw_r1 : saw_r0) begin
        t_ready = cyc - 1 - t0;
        if (!who) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
      end
      if (who ? saw_v1 : saw_v0) begin
        t_resp = cyc - 1 - t0;
        rdata  = who ? saw_d1 : saw_d0;
        done   = 1'b1;
      end
    end
    if (!done) chk("request_timeout", RW'(0), RW'(1));
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] base;
    base = ($urandom_range(0, 1) == 0) ? 17'h00000 : 17'h1F000;
    return base | AW'($urandom_range(0, 7) << 4) | AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int            tr, ts, wcb, vb;
    logic [RW-1:0] rd;
    logic [RW-1:0] pat_a5;
    logic [RW-1:0] pat_w;
    int            g [$];

    pat_a5 = {16{8'hA5}};
    pat_w  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_addr = '0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    bus.dout_b = '0;
    for (int i = 0; i < 8192; i++) ram[i] = init_line(i);
    model_reset();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_b", RW'(bus.addr_b), RW'(0));
    chk("reset_din_b", bus.din_b, RW'(0));
    chk("reset_we_b", RW'(bus.we_b), RW'(0));
    chk("reset_ready", RW'({bus.req0_ready, bus.req1_ready}), RW'(0));
    chk("reset_resp_valid", RW'({bus.req0_resp_valid, bus.req1_resp_valid}), RW'(0));
    chk("reset_resp0_data", bus.req0_resp_data, RW'(0));
    chk("reset_resp1_data", bus.req1_resp_data, RW'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read from req0.
    do_req(1'b0, 1'b0, 17'h00104, '0, tr, ts, rd);
    chk("read_ready_latency", RW'(tr), RW'(1));
    chk("read_resp_latency", RW'(ts), RW'(3));
    chk("read_data", rd, init_line(32'h10));

    // Write then read back on req1.
    wcb = we_cnt;
    do_req(1'b1, 1'b1, 17'h1F000, pat_a5, tr, ts, rd);
    chk("write_we_pulses", RW'(we_cnt - wcb), RW'(1));
    chk("write_resp_latency", RW'(ts), RW'(2));
    chk("write_resp_data", rd, RW'(0));
    do_req(1'b1, 1'b0, 17'h1F000, '0, tr, ts, rd);
    chk("readback_latency", RW'(ts), RW'(3));
    chk("readback_data", rd, pat_a5);

    // Tie: both valid continuously for 4 grants.
    bus.req0_valid = 1'b1; bus.req0_addr = 17'h00400;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 17'h00800;
    for (int k = 0; k < 40 && g.size() < 4; k++) begin
      tick();
      if (saw_r0) begin g.push_back(0); bus.req0_addr = bus.req0_addr + 17'h10; end
      if (saw_r1) begin g.push_back(1); bus.req1_addr = bus.req1_addr + 17'h10; end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (5) tick();
    chk("tie_grant_count", RW'(g.size()), RW'(4));
    for (int k = 0; k < 4 && k < g.size(); k++)
      chk("tie_grant_owner", RW'(g[k]), RW'(RR_MODE ? (k % 2) : 0));

    // rdy low during ISSUE of a write.
    bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = 17'h0C008; bus.req1_wdata = pat_w;
    tick();
    bus.rdy = 1'b0;
    wcb = we_cnt;
    repeat (3) begin
      tick();
      chk("rdylow_we_b", RW'(saw_we), RW'(0));
      chk("rdylow_ready", RW'(saw_r1), RW'(0));
      chk("rdylow_addr_b", RW'(saw_addr), RW'(17'h0C000));
    end
    bus.rdy = 1'b1;
    tick();
    chk("rdylow_release_we", RW'(saw_we), RW'(1));
    chk("rdylow_release_ready", RW'(saw_r1), RW'(1));
    bus.req1_valid = 1'b0;
    tick();
    chk("rdylow_resp_valid", RW'(saw_v1), RW'(1));
    chk("rdylow_we_pulses", RW'(we_cnt - wcb), RW'(1));
    do_req(1'b1, 1'b0, 17'h0C000, '0, tr, ts, rd);
    chk("rdylow_readback", rd, pat_w);

    // Reset during WAIT of a read.
    bus.req0_valid = 1'b1; bus.req0_addr = 17'h00230;
    tick();
    tick();
    chk("rstwait_ready", RW'(saw_r0), RW'(1));
    bus.req0_valid = 1'b0;
    vb = rv0_cnt; wcb = we_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("rstwait_no_resp", RW'(rv0_cnt - vb), RW'(0));
    chk("rstwait_no_we", RW'(we_cnt - wcb), RW'(0));
    chk("rstwait_addr_b", RW'(saw_addr), RW'(0));
    do_req(1'b0, 1'b0, 17'h00230, '0, tr, ts, rd);
    chk("rstwait_next_latency", RW'(ts), RW'(3));
    chk("rstwait_next_data", rd, init_line(32'h23));

    // Randomized traffic with random rdy stalls.
    for (int k = 0; k < 400; k++) begin
      bus.rdy = ($urandom_range(0, 4) != 0);
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) begin
        bus.req0_valid = 1'b1; bus.req0_addr = rand_addr();
      end
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) begin
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'($urandom_range(0, 1));
        bus.req1_addr  = rand_addr();
        bus.req1_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      tick();
      if (saw_r0) bus.req0_valid = 1'b0;
      if (saw_r1) bus.req1_valid = 1'b0;
    end
    bus.rdy = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
